// File: rtl/datamem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Contents: sequencer state encoding, requester index constants, default
// memory depth and the word-range check used to reject bad accesses.
package datamem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int RAM_SIZE_DEFAULT = 16;

  // True when addr is word aligned and its word index lies inside a memory
  // of 'size' words.
  function automatic logic word_ok(input logic [31:0] addr, input int size);
    logic [31:0] word_idx;
    logic [31:0] size_u;
    word_idx = {2'b00, addr[31:2]};
    size_u   = $unsigned(size);
    return (addr[1:0] == 2'b00) && (word_idx < size_u);
  endfunction

endpackage

// File: rtl/datamem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker.
// Ports:
//   req[1:0]  - request lines, bit i belongs to requester i
//   last      - index of the most recently granted requester
//   gnt_valid - at least one request is present
//   gnt_idx   - chosen requester (the one that was not granted last on a tie)
module rr_arb2
  import datamem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Pick a winner; on a tie the requester other than 'last' wins.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = M0;
    case (req)
      2'b01:   gnt_idx = M0;
      2'b10:   gnt_idx = M1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = M0;
    endcase
  end

endmodule

// File: rtl/datamem_arbiter.sv
// Round-robin arbiter and sequencer in front of a single-port, word-addressed
// data memory shared by the CPU data port (m0) and a DMA port (m1).
// Each transaction runs IDLE -> ACCESS (one cycle, memory enables driven)
// -> RESP (one-cycle ack). Misaligned or out-of-range addresses never enable
// the memory and complete with err=1 and rdata=0.
// Ports:
//   clk, reset                  - clock, asynchronous active-high reset
//   mN_req/wr/addr/wdata        - requester N transaction (held until ack)
//   mN_ack/err/rdata            - requester N completion pulse, error, data
//   mem_rd/wr/addr/wdata        - registered memory controls
//   mem_rdata                   - combinational memory read data
module datamem_arbiter
  import datamem_arbiter_pkg::*;
#(
  parameter int RAM_SIZE = RAM_SIZE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state, state_nxt;
  logic        rr_last, rr_last_nxt;
  logic        sel, sel_nxt;
  logic        bad, bad_nxt;

  logic        mem_rd_nxt, mem_wr_nxt;
  logic [31:0] mem_addr_nxt, mem_wdata_nxt;
  logic        m0_ack_nxt, m0_err_nxt, m1_ack_nxt, m1_err_nxt;
  logic [31:0] m0_rdata_nxt, m1_rdata_nxt;

  logic        arb_valid, arb_idx;
  logic        grant_go, grant_idx;
  logic        cand_wr, cand_bad;
  logic [31:0] cand_addr, cand_wdata;
  logic [31:0] captured;

  rr_arb2 u_rr_arb2 (
    .req       ({m1_req, m0_req}),
    .last      (rr_last),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  // Grant candidate: the picker in IDLE; in RESP only the requester that was
  // not just acked may be granted, since the acked one is still dropping req.
  always_comb begin
    grant_go  = 1'b0;
    grant_idx = M0;
    case (state)
      IDLE: begin
        grant_go  = arb_valid;
        grant_idx = arb_idx;
      end
      RESP: begin
        grant_idx = ~sel;
        if (sel == M0) begin
          grant_go = m1_req;
        end else begin
          grant_go = m0_req;
        end
      end
      default: begin
        grant_go  = 1'b0;
        grant_idx = M0;
      end
    endcase
    if (grant_idx == M1) begin
      cand_wr    = m1_wr;
      cand_addr  = m1_addr;
      cand_wdata = m1_wdata;
    end else begin
      cand_wr    = m0_wr;
      cand_addr  = m0_addr;
      cand_wdata = m0_wdata;
    end
    cand_bad = ~word_ok(cand_addr, RAM_SIZE);
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_nxt     = state;
    rr_last_nxt   = rr_last;
    sel_nxt       = sel;
    bad_nxt       = bad;
    mem_rd_nxt    = mem_rd;
    mem_wr_nxt    = mem_wr;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    m0_ack_nxt    = m0_ack;
    m0_err_nxt    = m0_err;
    m0_rdata_nxt  = m0_rdata;
    m1_ack_nxt    = m1_ack;
    m1_err_nxt    = m1_err;
    m1_rdata_nxt  = m1_rdata;

    // Writes and rejected accesses return zero data.
    if (mem_rd) begin
      captured = mem_rdata;
    end else begin
      captured = 32'h0000_0000;
    end

    case (state)
      IDLE, RESP: begin
        // Ack/err are only ever high during RESP; clear them on any exit.
        m0_ack_nxt = 1'b0;
        m0_err_nxt = 1'b0;
        m1_ack_nxt = 1'b0;
        m1_err_nxt = 1'b0;
        if (grant_go) begin
          state_nxt     = ACCESS;
          sel_nxt       = grant_idx;
          rr_last_nxt   = grant_idx;
          bad_nxt       = cand_bad;
          mem_addr_nxt  = cand_addr;
          mem_wdata_nxt = cand_wdata;
          mem_rd_nxt    = ~cand_wr & ~cand_bad;
          mem_wr_nxt    = cand_wr & ~cand_bad;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS: begin
        state_nxt  = RESP;
        mem_rd_nxt = 1'b0;
        mem_wr_nxt = 1'b0;
        if (sel == M1) begin
          m1_ack_nxt   = 1'b1;
          m1_err_nxt   = bad;
          m1_rdata_nxt = captured;
        end else begin
          m0_ack_nxt   = 1'b1;
          m0_err_nxt   = bad;
          m0_rdata_nxt = captured;
        end
      end
      default: begin
        state_nxt  = IDLE;
        mem_rd_nxt = 1'b0;
        mem_wr_nxt = 1'b0;
        m0_ack_nxt = 1'b0;
        m0_err_nxt = 1'b0;
        m1_ack_nxt = 1'b0;
        m1_err_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs; rr_last resets to M1 so m0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_last   <= M1;
      sel       <= M0;
      bad       <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      m0_ack    <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= 32'h0000_0000;
      m1_ack    <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= 32'h0000_0000;
    end else begin
      state     <= state_nxt;
      rr_last   <= rr_last_nxt;
      sel       <= sel_nxt;
      bad       <= bad_nxt;
      mem_rd    <= mem_rd_nxt;
      mem_wr    <= mem_wr_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      m0_ack    <= m0_ack_nxt;
      m0_err    <= m0_err_nxt;
      m0_rdata  <= m0_rdata_nxt;
      m1_ack    <= m1_ack_nxt;
      m1_err    <= m1_err_nxt;
      m1_rdata  <= m1_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Self-checking bench for datamem_arbiter with a 16-word memory model and a
// transaction-level reference (expected data/err from address arithmetic).
module tb_datamem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] tb_mem  [16];   // the memory the DUT drives
  logic [31:0] ref_mem [16];   // expected contents from transaction intent

  datamem_arbiter #(.RAM_SIZE(16)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem_rd ? tb_mem[mem_addr[5:2]] : 32'h0;
  always @(posedge clk) if (mem_wr) tb_mem[mem_addr[5:2]] <= mem_wdata;

  function automatic bit exp_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= 16);
  endfunction

  // Runs one transaction on requester idx and reports what was observed.
  task automatic do_txn(input bit idx, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat, output bit saw_rd,
                        output bit saw_wr, output bit overlap);
    bit got = 0;
    rdata = 32'h0; err = 1'b0; lat = -1; saw_rd = 0; saw_wr = 0; overlap = 0;
    @(posedge clk); #1;
    if (idx) begin m1_req = 1; m1_wr = wr; m1_addr = addr; m1_wdata = wdata; end
    else     begin m0_req = 1; m0_wr = wr; m0_addr = addr; m0_wdata = wdata; end
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge clk);
      if (mem_rd) saw_rd = 1;
      if (mem_wr) saw_wr = 1;
      if (idx ? m0_ack : m1_ack) overlap = 1;
      if (idx ? m1_ack : m0_ack) begin
        got = 1; lat = c;
        rdata = idx ? m1_rdata : m0_rdata;
        err = idx ? m1_err : m0_err;
      end
    end
    @(posedge clk); #1;
    if (idx) m1_req = 0; else m0_req = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m0_ack, m0_err, m1_ack, m1_err, mem_rd, mem_wr} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0", {m0_ack, m0_err, m1_ack, m1_err, mem_rd, mem_wr});
    end
    checks++;
    if ({m0_rdata, m1_rdata, mem_addr, mem_wdata} !== 128'b0) begin
      errors++; $display("FAIL reset_data got %h want 0", {m0_rdata, m1_rdata, mem_addr, mem_wdata});
    end
    reset = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m0_ack, m1_ack, mem_rd, mem_wr} !== 4'b0) begin
      errors++; $display("FAIL idle_after_reset got %b want 0", {m0_ack, m1_ack, mem_rd, mem_wr});
    end
  endtask

  // Writes every word with random data so later reads have known contents.
  task automatic test_fill();
    logic [31:0] rd, v; logic er; int lat; bit sr, sw, ov;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      do_txn(i[0], 1'b1, 32'(i * 4), v, rd, er, lat, sr, sw, ov);
      ref_mem[i] = v;
      checks++;
      if (er !== 1'b0 || lat != 3 || !sw || ov) begin
        errors++; $display("FAIL fill_%0d err=%b lat=%0d wr=%b ovl=%b want 0/3/1/0", i, er, lat, sw, ov);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int lat; bit sr, sw, ov;
    @(posedge clk); #1;
    m0_req = 1; m0_wr = 1; m0_addr = 32'h8; m0_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 32'h8 || mem_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_access wr=%b rd=%b addr=%h data=%h want 1/0/8/deadbeef", mem_wr, mem_rd, mem_addr, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m1_ack !== 1'b0) begin
      errors++; $display("FAIL wr_ack ack=%b err=%b m1_ack=%b want 1/0/0", m0_ack, m0_err, m1_ack);
    end
    @(posedge clk); #1; m0_req = 0;
    ref_mem[2] = 32'hDEAD_BEEF;
    do_txn(1'b0, 1'b0, 32'h8, 32'h0, rd, er, lat, sr, sw, ov);
    checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat != 3 || !sr || sw) begin
      errors++; $display("FAIL rd_back got %h err=%b lat=%0d want deadbeef/0/3", rd, er, lat);
    end
  endtask

  task automatic test_contention();
    int ord[$]; int tim[$]; bit ovl = 0; int cnt0 = 0, cnt1 = 0;
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    m0_req = 1; m0_wr = 0; m0_addr = 32'h0;
    m1_req = 1; m1_wr = 0; m1_addr = 32'h4;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (m0_ack && m1_ack) ovl = 1;
      if (m0_ack) begin
        ord.push_back(0); tim.push_back(c); cnt0++;
        checks++;
        if (m0_rdata !== ref_mem[0]) begin
          errors++; $display("FAIL cont_m0_data got %h want %h", m0_rdata, ref_mem[0]);
        end
      end
      if (m1_ack) begin
        ord.push_back(1); tim.push_back(c); cnt1++;
        checks++;
        if (m1_rdata !== ref_mem[1]) begin
          errors++; $display("FAIL cont_m1_data got %h want %h", m1_rdata, ref_mem[1]);
        end
      end
      @(posedge clk); #1;
      if (cnt0 >= 2) m0_req = 0;
      if (cnt1 >= 2) m1_req = 0;
    end
    checks++;
    if (ord.size() != 4 || ovl) begin
      errors++; $display("FAIL cont_count got %0d acks ovl=%b want 4/0", ord.size(), ovl);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ord[k] != (k % 2) || tim[k] != 3 + 2 * k) begin
          errors++; $display("FAIL cont_order_%0d got m%0d@%0d want m%0d@%0d", k, ord[k], tim[k], k % 2, 3 + 2 * k);
        end
      end
    end
  endtask

  task automatic test_bad_range();
    logic [31:0] rd; logic er; int lat; bit sr, sw, ov;
    do_txn(1'b1, 1'b0, 32'h8, 32'h0, rd, er, lat, sr, sw, ov);
    checks++;
    if (rd !== ref_mem[2] || er !== 1'b0) begin
      errors++; $display("FAIL m1_read got %h err=%b want %h/0", rd, er, ref_mem[2]);
    end
    do_txn(1'b1, 1'b0, 32'h40, 32'h0, rd, er, lat, sr, sw, ov);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1 || lat != 3 || sr || sw || ov) begin
      errors++; $display("FAIL range got %h err=%b lat=%0d rd=%b wr=%b want 0/1/3/0/0", rd, er, lat, sr, sw);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er; int lat; bit sr, sw, ov;
    do_txn(1'b0, 1'b1, 32'h6, 32'hCAFE_F00D, rd, er, lat, sr, sw, ov);
    checks++;
    if (er !== 1'b1 || sw || sr || lat != 3) begin
      errors++; $display("FAIL misalign err=%b wr=%b lat=%0d want 1/0/3", er, sw, lat);
    end
    do_txn(1'b0, 1'b0, 32'h4, 32'h0, rd, er, lat, sr, sw, ov);
    checks++;
    if (rd !== ref_mem[1] || er !== 1'b0) begin
      errors++; $display("FAIL misalign_back got %h want %h", rd, ref_mem[1]);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd; logic er; int lat; bit sr, sw, ov;
    @(posedge clk); #1;
    m1_req = 1; m1_wr = 1; m1_addr = 32'hC; m1_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    checks++;
    if (mem_wr !== 1'b1) begin
      errors++; $display("FAIL abort_access got mem_wr=%b want 1", mem_wr);
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({m0_ack, m0_err, m1_ack, m1_err, mem_rd, mem_wr} !== 6'b0 ||
        {m0_rdata, m1_rdata, mem_addr, mem_wdata} !== 128'b0) begin
      errors++; $display("FAIL abort_outputs got ctrl=%b addr=%h want 0", {m0_ack, m1_ack, mem_rd, mem_wr}, mem_addr);
    end
    m1_req = 0; m1_wr = 0;
    @(posedge clk); #1 reset = 0;
    do_txn(1'b0, 1'b0, 32'hC, 32'h0, rd, er, lat, sr, sw, ov);
    checks++;
    if (rd !== ref_mem[3] || er !== 1'b0 || lat != 3) begin
      errors++; $display("FAIL abort_back got %h lat=%0d want %h/3", rd, lat, ref_mem[3]);
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0; bit want_ack, want_rd;
    @(posedge clk); #1;
    m0_req = 1; m0_wr = 0; m0_addr = 32'h8;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      want_ack = (c % 3 == 0) && (c <= 9);
      want_rd  = (c % 3 == 2) && (c <= 8);
      checks++;
      if (m0_ack !== want_ack || mem_rd !== want_rd || m1_ack !== 1'b0) begin
        errors++; $display("FAIL b2b_c%0d ack=%b rd=%b m1_ack=%b want %b/%b/0", c, m0_ack, mem_rd, m1_ack, want_ack, want_rd);
      end
      if (m0_ack) begin
        acks++;
        checks++;
        if (m0_rdata !== ref_mem[2]) begin
          errors++; $display("FAIL b2b_data got %h want %h", m0_rdata, ref_mem[2]);
        end
      end
      @(posedge clk); #1;
      if (acks >= 3) m0_req = 0;
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, v, want; logic er; int lat; bit sr, sw, ov, idx, wr, bad;
    int r;
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 1);
      wr  = $urandom_range(0, 1);
      v   = $urandom;
      r   = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, 15) * 4);
      else if (r == 7) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else             a = 32'h40 + 32'($urandom_range(0, 1000) * 4) + (r == 9 ? 32'h8000_0000 : 32'h0);
      bad  = exp_bad(a);
      want = (!wr && !bad) ? ref_mem[a / 4] : 32'h0;
      do_txn(idx, wr, a, v, rd, er, lat, sr, sw, ov);
      if (wr && !bad) ref_mem[a / 4] = v;
      checks++;
      if (rd !== want || er !== bad || lat != 3 || sr != (!wr && !bad) || sw != (wr && !bad) || ov) begin
        errors++;
        $display("FAIL rand_%0d m%0d wr=%b a=%h got d=%h e=%b lat=%0d r=%b w=%b ov=%b want d=%h e=%b", n, idx, wr, a, rd, er, lat, sr, sw, ov, want, bad);
      end
    end
  endtask

  initial begin
    reset = 1; m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0;
    test_reset();
    test_fill();
    test_write_read();
    test_contention();
    test_bad_range();
    test_misaligned();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port word-addressed data memory.
- Shares the memory between the CPU data port (m0) and a DMA/peripheral port (m1).
- Uses a req/ack handshake per requester and drives the memory's rd/wr/addr/wdata.
- Blocks misaligned or out-of-range accesses before they reach memory and reports them as errors.

Parameters:
- RAM_SIZE, 16, memory depth in 32-bit words; must match the memory instance.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- m0_req  input  1  requester 0 transaction request; held high until m0_ack.
- m0_wr  input  1  1 = write, 0 = read; stable while m0_req is high.
- m0_addr  input  32  byte address; stable while m0_req is high.
- m0_wdata  input  32  write data; stable while m0_req is high.
- m0_ack  output  1  one-cycle completion pulse.
- m0_err  output  1  valid with m0_ack; 1 = access rejected.
- m0_rdata  output  32  read data, valid with m0_ack.
- m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as the m0 ports, for requester 1.
- mem_rd  output  1  memory read enable.
- mem_wr  output  1  memory write enable; the write commits on the clk edge that ends ACCESS.
- mem_addr  output  32  memory byte address.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data, combinational from mem_addr/mem_rd.

Behaviour:
- Reset (asynchronous): state=IDLE, rr_last=1 (so m0 wins the first tie). All outputs are 0: acks, errs, rdata, mem_rd, mem_wr, mem_addr, mem_wdata.
- States: IDLE, ACCESS, RESP.
- IDLE, no request pending: stay in IDLE.
- IDLE, request pending: grant one requester.
  - Single request: grant it.
  - Both requesting: grant the one not equal to rr_last.
  - On grant: latch sel, wr, addr and wdata; set rr_last=sel; go to ACCESS.
  - Compute bad = (addr[1:0]!=0) || (addr[31:2] >= RAM_SIZE).
- mem_* outputs are registered and loaded on entry to ACCESS:
  - mem_addr = latched address; mem_wdata = latched write data.
  - mem_rd = !wr & !bad; mem_wr = wr & !bad.
  - When bad, both enables are 0, so the memory is never touched.
- ACCESS: lasts exactly one cycle.
  - At its closing edge, mem_rdata is captured into m<sel>_rdata; the captured value is 0 for a write or a bad access.
  - At the same edge, m<sel>_ack=1 and m<sel>_err=bad are set, mem_rd and mem_wr are cleared, and the state goes to RESP.
- RESP: the ack is high for exactly this cycle.
  - The acked requester's req is ignored in this cycle, because the requester drops or re-presents it afterwards.
  - If the other requester's req is high: grant it directly and go to ACCESS, loading mem_* as above. This allows back-to-back alternation.
  - Otherwise go to IDLE.
  - The ack and err clear on leaving RESP. rdata holds until the next ack to that requester.
- Latency: req is sampled at edge N; ACCESS runs in cycle N+1; ack is high in cycle N+2.
- Throughput:
  - One requester alone: one transaction every 3 cycles.
  - Both requesters: alternate, one transaction every 2 cycles.
- Fairness: under continuous contention, grants strictly alternate m0, m1, m0, and so on. Starvation is impossible.
- Only one ack is ever high in any cycle.
- Reset mid-operation:
  - Reset during ACCESS before the commit edge: the write is aborted and memory is unchanged.
  - Reset during RESP: the ack is dropped immediately.
  - Requesters must re-issue after reset.
- A req deasserted before its ack is a protocol violation; behaviour is undefined and no recovery is required.

Decomposition:
- Shared package:
  - State enum {IDLE, ACCESS, RESP}.
  - Requester-index constants M0=0, M1=1.
  - RAM_SIZE default.
  - Range-check function word_ok(addr, size).
- One sub-module: rr_arb2, a combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt_valid, gnt_idx.

Test Plan:
- m0 writes 0xDEADBEEF to address 0x8 with m1 idle → mem_wr=1, mem_addr=0x8 in cycle N+1; m0_ack=1, m0_err=0 in cycle N+2. A following m0 read of 0x8 returns m0_rdata=0xDEADBEEF.
- m0 and m1 both request reads from reset, held continuously → grant order m0, m1, m0, m1; acks are 2 cycles apart and never overlap.
- m1 reads address 0x40 (word 16 == RAM_SIZE) → mem_rd=0, mem_wr=0 throughout; m1_ack=1, m1_err=1, m1_rdata=0.
- m0 writes to address 0x6 (misaligned) → no mem_wr pulse; m0_err=1; the word at 0x4 is unchanged on readback.
- m1 write of 0x12345678 to 0xC, with reset asserted mid-ACCESS before the clock edge → all outputs 0 asynchronously, state IDLE; a readback of 0xC shows the old value.
- m0 issues back-to-back reads, dropping req for 0 cycles after each ack, with m1 idle → ack every 3 cycles; m0 is re-granted only after passing through IDLE.
